// File: rtl/sky130_fd_io__pwrseq_pkg.sv
// rtl/sky130_fd_io__pwrseq_pkg.sv - shared types and helpers for the HVC power-pad sequencer
//
// Purpose: holds the sequencer state encoding, the STATE output width and the
// helper that sizes the FAULT_CH output from the rail count.
// Ports: none (package).

package sky130_fd_io__pwrseq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PS_OFF     = 3'd0,
        PS_RAMP_UP = 3'd1,
        PS_ON      = 3'd2,
        PS_RAMP_DN = 3'd3,
        PS_FAULT   = 3'd4
    } pwrseq_state_e;

    // FAULT_CH / rail-index width: max(1, clog2(nch)).
    function automatic int fault_ch_width(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/sky130_fd_io__pwrseq_debounce.sv
// rtl/sky130_fd_io__pwrseq_debounce.sv - per-rail power-good synchroniser and debouncer
//
// Purpose: brings one asynchronous raw power-good into the CLK domain through
// a 2-flop synchroniser, then only lets Q follow after DEB_LEN consecutive
// synchronised samples that disagree with Q. Raw edge to Q change is
// 2 + DEB_LEN cycles.
// Ports:
//   CLK    in   sequencer clock
//   RST    in   asynchronous active-high reset
//   D_RAW  in   raw power-good comparator output (asynchronous)
//   Q      out  debounced power-good

module sky130_fd_io__pwrseq_debounce #(
    parameter int DEB_LEN = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic D_RAW,
    output logic Q
);

    localparam logic [7:0] CNT_LAST = 8'(DEB_LEN - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       q_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       q_d;

    // Counter tracks how many consecutive samples disagree with Q; any
    // agreeing sample restarts the count so glitches shorter than DEB_LEN
    // never reach Q.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (sync2_q == q_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            q_d   = ~q_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            q_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= D_RAW;
            sync2_q <= sync1_q;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/sky130_fd_io__top_power_seq_hvc.sv
// rtl/sky130_fd_io__top_power_seq_hvc.sv - multi-rail power-pad sequencer for the HVC pad ring
//
// Purpose: ramps NCH power rails up in ascending order and down in descending
// order, gating each step on the rail's debounced power-good, and latches a
// fault when a rail drops while ON (or, with the timeout option, fails to
// come up in time).
// Optional feature: define SKY130_FD_IO_PWRSEQ_TIMEOUT_EN to add the per-step
// timer (TIMEOUT cycles); without it the ramps wait indefinitely on PG[k].
// Ports:
//   CLK       in   sequencer clock
//   RST       in   asynchronous active-high reset
//   START     in   level, request power-up
//   STOP      in   level, request power-down (wins over START)
//   CLR       in   pulse, clear a latched fault (only when PG is all zero)
//   PG_RAW    in   [NCH] raw asynchronous power-good per rail
//   EN        out  [NCH] rail enable per rail
//   PG        out  [NCH] debounced power-good per rail
//   READY     out  all rails up (state ON)
//   FAULT     out  latched fault
//   FAULT_CH  out  index of the faulting rail
//   STATE     out  current state encoding

module sky130_fd_io__top_power_seq_hvc
    import sky130_fd_io__pwrseq_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DEB_LEN = 8,
    parameter int TIMEOUT = 1024,
    localparam int CHW    = fault_ch_width(NCH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               STOP,
    input  logic               CLR,
    input  logic [NCH-1:0]     PG_RAW,
    output logic [NCH-1:0]     EN,
    output logic [NCH-1:0]     PG,
    output logic               READY,
    output logic               FAULT,
    output logic [CHW-1:0]     FAULT_CH,
    output logic [STATE_W-1:0] STATE
);

    localparam logic [CHW-1:0] K_LAST = CHW'(NCH - 1);

    generate
        if (NCH < 1 || NCH > 16 || DEB_LEN < 1 || DEB_LEN > 255 ||
            TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
            $error("sky130_fd_io__top_power_seq_hvc: parameter out of range");
        end
    endgenerate

    logic [NCH-1:0] pg_w;

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_rail
            sky130_fd_io__pwrseq_debounce #(
                .DEB_LEN (DEB_LEN)
            ) u_debounce (
                .CLK   (CLK),
                .RST   (RST),
                .D_RAW (PG_RAW[g]),
                .Q     (pg_w[g])
            );
        end
    endgenerate

    pwrseq_state_e  state_q, state_d;
    logic [CHW-1:0] k_q, k_d;
    logic [NCH-1:0] en_q, en_d;
    logic [CHW-1:0] fault_ch_q, fault_ch_d;
    logic [CHW-1:0] low_zero;

`ifdef SKY130_FD_IO_PWRSEQ_TIMEOUT_EN
    localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);
    logic [15:0] timer_q, timer_d;
    logic        timer_exp;
    assign timer_exp = (timer_q == T_LAST);
`endif

    // Lowest rail whose debounced power-good is low.
    always_comb begin
        low_zero = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!pg_w[i]) begin
                low_zero = CHW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        en_d       = en_q;
        fault_ch_d = fault_ch_q;
`ifdef SKY130_FD_IO_PWRSEQ_TIMEOUT_EN
        // Timer clears on every state or k change; it only counts while a
        // step is waiting.
        timer_d    = '0;
`endif
        case (state_q)
            PS_OFF: begin
                en_d = '0;
                if (START && !STOP) begin
                    state_d = PS_RAMP_UP;
                    k_d     = '0;
                    en_d[0] = 1'b1;
                end
            end

            PS_RAMP_UP: begin
                if (STOP) begin
                    // Unwind from the rail currently being brought up.
                    state_d   = PS_RAMP_DN;
                    en_d[k_q] = 1'b0;
                end else if (pg_w[k_q]) begin
                    if (k_q == K_LAST) begin
                        state_d = PS_ON;
                    end else begin
                        k_d       = k_q + 1'b1;
                        en_d[k_d] = 1'b1;
                    end
                end
`ifdef SKY130_FD_IO_PWRSEQ_TIMEOUT_EN
                else if (timer_exp) begin
                    state_d    = PS_FAULT;
                    en_d       = '0;
                    fault_ch_d = k_q;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
`endif
            end

            PS_ON: begin
                // A rail drop beats a simultaneous STOP.
                if (!(&pg_w)) begin
                    state_d    = PS_FAULT;
                    en_d       = '0;
                    fault_ch_d = low_zero;
                end else if (STOP) begin
                    state_d      = PS_RAMP_DN;
                    k_d          = K_LAST;
                    en_d[K_LAST] = 1'b0;
                end
            end

            PS_RAMP_DN: begin
`ifdef SKY130_FD_IO_PWRSEQ_TIMEOUT_EN
                // A rail that never reports down is abandoned after the
                // limit; this is a normal step, not a fault.
                if (!pg_w[k_q] || timer_exp) begin
`else
                if (!pg_w[k_q]) begin
`endif
                    if (k_q == '0) begin
                        state_d = PS_OFF;
                    end else begin
                        k_d       = k_q - 1'b1;
                        en_d[k_d] = 1'b0;
                    end
                end
`ifdef SKY130_FD_IO_PWRSEQ_TIMEOUT_EN
                else begin
                    timer_d = timer_q + 16'd1;
                end
`endif
            end

            PS_FAULT: begin
                en_d = '0;
                if (CLR && (pg_w == '0)) begin
                    state_d    = PS_OFF;
                    fault_ch_d = '0;
                    k_d        = '0;
                end
            end

            default: begin
                // Encodings 5..7 only appear through upset; fail safe.
                state_d    = PS_FAULT;
                en_d       = '0;
                fault_ch_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= PS_OFF;
            k_q        <= '0;
            en_q       <= '0;
            fault_ch_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            en_q       <= en_d;
            fault_ch_q <= fault_ch_d;
        end
    end

`ifdef SKY130_FD_IO_PWRSEQ_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign EN       = en_q;
    assign PG       = pg_w;
    assign READY    = (state_q == PS_ON);
    assign FAULT    = (state_q == PS_FAULT);
    assign FAULT_CH = fault_ch_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_sky130_fd_io__top_power_seq_hvc.sv
// tb/tb_sky130_fd_io__top_power_seq_hvc.sv - directed self-checking bench for the power sequencer

module tb_sky130_fd_io__top_power_seq_hvc;

    localparam int NCH = 4;

    logic           CLK;
    logic           RST;
    logic           START;
    logic           STOP;
    logic           CLR;
    logic [NCH-1:0] PG_RAW;
    logic [NCH-1:0] EN;
    logic [NCH-1:0] PG;
    logic           READY;
    logic           FAULT;
    logic [1:0]     FAULT_CH;
    logic [2:0]     STATE;

    sky130_fd_io__top_power_seq_hvc #(
        .NCH     (NCH),
        .DEB_LEN (2),
        .TIMEOUT (16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .STOP     (STOP),
        .CLR      (CLR),
        .PG_RAW   (PG_RAW),
        .EN       (EN),
        .PG       (PG),
        .READY    (READY),
        .FAULT    (FAULT),
        .FAULT_CH (FAULT_CH),
        .STATE    (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Rail model: each PG_RAW bit follows EN three samples later, minus drops.
    logic [NCH-1:0] h0, h1, h2;
    logic [NCH-1:0] drop_mask;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic upd_pg();
        PG_RAW = h2 & ~drop_mask;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        h2 = h1;
        h1 = h0;
        h0 = EN;
        upd_pg();
    endtask

    task automatic wait_en(input logic [NCH-1:0] exp, input string tag);
        int n = 0;
        while (EN !== exp && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(EN), 32'(exp));
    endtask

    task automatic wait_state(input logic [2:0] exp, input string tag);
        int n = 0;
        while (STATE !== exp && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(STATE), 32'(exp));
    endtask

    task automatic wait_pg_zero(input string tag);
        int n = 0;
        while (PG !== '0 && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(PG), 32'd0);
    endtask

    initial begin
        int n;
        RST = 1'b1; START = 1'b0; STOP = 1'b0; CLR = 1'b0;
        drop_mask = '0; h0 = '0; h1 = '0; h2 = '0; PG_RAW = '0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check_eq("rst_en",       32'(EN),       32'd0);
        check_eq("rst_pg",       32'(PG),       32'd0);
        check_eq("rst_ready",    32'(READY),    32'd0);
        check_eq("rst_fault",    32'(FAULT),    32'd0);
        check_eq("rst_fault_ch", 32'(FAULT_CH), 32'd0);
        check_eq("rst_state",    32'(STATE),    32'd0);

        // START and STOP together: STOP wins, stay OFF.
        START = 1'b1; STOP = 1'b1;
        repeat (5) tick();
        check_eq("both_state", 32'(STATE), 32'd0);
        check_eq("both_en",    32'(EN),    32'd0);
        STOP = 1'b0;

        // Full ramp up.
        wait_en(4'b0001, "up_en0");
        wait_en(4'b0011, "up_en1");
        wait_en(4'b0111, "up_en2");
        wait_en(4'b1111, "up_en3");
        check_eq("ready_early", 32'(READY), 32'd0);
        wait_state(3'd2, "up_on");
        check_eq("up_ready", 32'(READY), 32'd1);
        check_eq("up_fault", 32'(FAULT), 32'd0);
        check_eq("up_pg",    32'(PG),    32'hF);
        START = 1'b0;

        // One-cycle glitch on rail 2 is filtered.
        drop_mask = 4'b0100; upd_pg();
        tick();
        drop_mask = '0; upd_pg();
        repeat (8) tick();
        check_eq("glitch_state", 32'(STATE), 32'd2);
        check_eq("glitch_pg",    32'(PG),    32'hF);
        check_eq("glitch_fault", 32'(FAULT), 32'd0);

        // Sustained drop on rail 2: fault after 2 + 2 + 1 cycles.
        drop_mask = 4'b0100; upd_pg();
        n = 0;
        while (FAULT !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        drop_mask = '0; upd_pg();
        check_eq("fault_lat",   32'(n),        32'd5);
        check_eq("fault_flag",  32'(FAULT),    32'd1);
        check_eq("fault_ch",    32'(FAULT_CH), 32'd2);
        check_eq("fault_en",    32'(EN),       32'd0);
        check_eq("fault_state", 32'(STATE),    32'd4);

        // CLR while some PG still high is ignored.
        CLR = 1'b1; tick(); CLR = 1'b0;
        check_eq("clr_ign_state", 32'(STATE),    32'd4);
        check_eq("clr_ign_ch",    32'(FAULT_CH), 32'd2);
        wait_pg_zero("clr_pg_zero");
        CLR = 1'b1; tick(); CLR = 1'b0;
        check_eq("clr_state", 32'(STATE),    32'd0);
        check_eq("clr_fault", 32'(FAULT),    32'd0);
        check_eq("clr_ch",    32'(FAULT_CH), 32'd0);

        // Ramp up, then orderly ramp down.
        START = 1'b1;
        wait_en(4'b1111, "up2_en3");
        wait_state(3'd2, "up2_on");
        START = 1'b0; STOP = 1'b1;
        wait_en(4'b0111, "dn_en3");
        check_eq("dn_ready", 32'(READY), 32'd0);
        wait_en(4'b0011, "dn_en2");
        wait_en(4'b0001, "dn_en1");
        wait_en(4'b0000, "dn_en0");
        wait_state(3'd0, "dn_off");
        STOP = 1'b0;

        // STOP during ramp up at k=1: EN[1] clears first, then EN[0].
        START = 1'b1;
        wait_en(4'b0011, "stk_en1");
        STOP = 1'b1;
        tick();
        check_eq("stk_first", 32'(EN),    32'b0001);
        check_eq("stk_state", 32'(STATE), 32'd3);
        wait_en(4'b0000, "stk_en0");
        wait_state(3'd0, "stk_off");
        START = 1'b0; STOP = 1'b0;

        // Rail 1 never comes up.
        drop_mask = 4'b0010; upd_pg();
        START = 1'b1;
        wait_en(4'b0011, "to_en1");
`ifdef SKY130_FD_IO_PWRSEQ_TIMEOUT_EN
        n = 0;
        while (FAULT !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_eq("to_lat", 32'(n),        32'd16);
        check_eq("to_ch",  32'(FAULT_CH), 32'd1);
        check_eq("to_en",  32'(EN),       32'd0);
        START = 1'b0;
        wait_pg_zero("to_pg_zero");
        CLR = 1'b1; tick(); CLR = 1'b0;
        check_eq("to_clr_state", 32'(STATE), 32'd0);
        START = 1'b1;
`else
        repeat (1000) tick();
        check_eq("nto_state", 32'(STATE), 32'd1);
        check_eq("nto_fault", 32'(FAULT), 32'd0);
        check_eq("nto_en",    32'(EN),    32'b0011);
`endif
        drop_mask = '0; upd_pg();

        // Asynchronous reset with all rails enabled.
        wait_en(4'b1111, "ar_en3");
        #2;
        RST = 1'b1;
        #1;
        check_eq("ar_en", 32'(EN), 32'd0);
        check_eq("ar_pg", 32'(PG), 32'd0);
        START = 1'b0;
        h0 = '0; h1 = '0; h2 = '0; upd_pg();
        repeat (2) tick();
        RST = 1'b0;
        tick();
        check_eq("ar_state",    32'(STATE), 32'd0);
        check_eq("ar_en_after", 32'(EN),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
